alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports in this order (name, direction, width, meaning):
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  instruction offered.
- IN_READY  out  1  block can accept an instruction.
- INSTR  in  32  RV32I instruction word.
- RS1_VAL  in  32  rs1 value.
- RS2_VAL  in  32  rs2 value.
- OP1  out  32  registered ALU operand 1.
- OP2  out  32  registered ALU operand 2.
- CTL  out  5  registered ALU operation code (defs.v ALU_* codes).
- ALU_OUT  in  32  combinational ALU result for OP1/OP2/CTL.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer takes the result.
- RES  out  32  result.
- RES_RD  out  5  destination register; 0 for branches and illegal instructions.
- RES_BR  out  1  result is a branch-taken flag.
- ILLEGAL  out  1  instruction not decodable.

Function
REQ-002 SHALL implement FSM states IDLE, EXEC and DONE.
- IDLE: IN_VALID -> EXEC.
- EXEC: unconditional -> DONE.
- DONE: RES_READY with no new IN_VALID -> IDLE; RES_READY with IN_VALID -> EXEC.
REQ-003 SHALL assert IN_READY only in IDLE, or in DONE while RES_READY=1.
REQ-004 Handshake:
- An instruction is accepted on any cycle with IN_VALID=1 and IN_READY=1.
- On acceptance, SHALL decode INSTR and register OP1, OP2, CTL, RES_RD, RES_BR and ILLEGAL.
REQ-005 SHALL capture ALU_OUT during EXEC into RES, and assert RES_VALID in DONE. Latency: accept on cycle N gives RES_VALID on cycle N+2.
REQ-006 SHALL hold RES, RES_RD, RES_BR and ILLEGAL stable while RES_VALID=1 and RES_READY=0.
REQ-007 SHALL drive OP1=0, OP2=0, CTL=ALU_ADD in IDLE, so the ALU never sees an undefined code.
REQ-008 R-type (opcode 0110011) decode:
- OP1=RS1_VAL; OP2=RS2_VAL, except for shifts, where OP2={27'b0,RS2_VAL[4:0]}.
- funct3 mapping: 000 ADD, or SUB when funct7=0100000; 001 SLL; 010 LT; 011 LTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND.
REQ-009 I-type ALU (opcode 0010011) decode:
- OP2 = sign-extended INSTR[31:20].
- Shifts: OP2={27'b0,INSTR[24:20]}; SRAI selected by INSTR[30]=1.
- funct3 mapping as REQ-008, but no SUB.
REQ-010 ILLEGAL=1 when any of the following holds:
- Unsupported opcode.
- R-type funct7 is neither 0000000 nor 0100000.
- funct7=0100000 with funct3 other than 000/101.
- I-type shift funct7 mismatch.
REQ-011 An illegal instruction SHALL still complete the handshake, with RES=0 and RES_RD=0.
REQ-012 RES_RD=INSTR[11:7] for legal R/I instructions.

Reset
REQ-013 With RST=1 at a clock edge, the block SHALL enter IDLE and clear all of: RES_VALID, RES, RES_RD, RES_BR, ILLEGAL, OP1, OP2. CTL SHALL reset to ALU_ADD.
REQ-014 RST during EXEC or DONE SHALL discard the in-flight instruction; no RES_VALID pulse follows.
REQ-015 IN_READY SHALL read 1 on the first cycle after RST deasserts.

Configuration
REQ-016 Macro ALU_ISSUE_BRANCH_EN, when defined, SHALL enable branch decode (opcode 1100011):
- OP1=RS1_VAL, OP2=RS2_VAL, RES_BR=1, RES_RD=0.
- funct3 mapping: 000 EQ; 001 NE; 100 LT; 101 GE; 110 LTU; 111 issues LTU with the captured bit inverted.
- funct3 010/011 are illegal.
- RES={31'b0, ALU_OUT[0] or its inversion}.
REQ-017 Without ALU_ISSUE_BRANCH_EN, opcode 1100011 SHALL be ILLEGAL and RES_BR SHALL be constant 0.

Verification
REQ-018 Bench SHALL cover, with an ALU model attached:
- ADD x3,x1,x2 with RS1=5, RS2=7: accepted cycle N -> RES_VALID cycle N+2, RES=12, RES_RD=3, ILLEGAL=0.
- SRA R-type with RS1=0x80000000, RS2=0x00000021: OP2=1, RES=0xC0000000.
- ADDI with imm=0xFFF, RS1=1 -> RES=0; RES_READY held 0 for 5 cycles -> RES and RES_VALID stable, IN_READY=0.
- Back-to-back: two instructions, RES_READY=1 and IN_VALID=1 in DONE -> second result 2 cycles after first, no IDLE cycle.
- With ALU_ISSUE_BRANCH_EN, BGEU with RS1=3, RS2=3 -> RES=1, RES_BR=1. Without the macro, the same instruction -> ILLEGAL=1, RES=0.
- RST asserted in EXEC -> next cycle IDLE, RES_VALID stays 0, IN_READY=1.

Source files
------------

// File: rtl/alu_issue.sv
`default_nettype none
//==========================================================================
// Module   : alu_issue
// Purpose  : RV32I ALU issue stage. It decodes one instruction, drives an
//            external combinational ALU and holds the result under a
//            valid/ready handshake. Define ALU_ISSUE_BRANCH_EN to add
//            conditional-branch decode.
// Revision : 1.0
//==========================================================================
module alu_issue (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] RS1_VAL,
    input  logic [31:0] RS2_VAL,
    output logic [31:0] OP1,
    output logic [31:0] OP2,
    output logic [4:0]  CTL,
    input  logic [31:0] ALU_OUT,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [31:0] RES,
    output logic [4:0]  RES_RD,
    output logic        RES_BR,
    output logic        ILLEGAL
);

    localparam logic [4:0] c_ALU_ADD = 5'd0;
    localparam logic [4:0] c_ALU_SUB = 5'd1;
    localparam logic [4:0] c_ALU_SLL = 5'd2;
    localparam logic [4:0] c_ALU_LT  = 5'd3;
    localparam logic [4:0] c_ALU_LTU = 5'd4;
    localparam logic [4:0] c_ALU_XOR = 5'd5;
    localparam logic [4:0] c_ALU_SRL = 5'd6;
    localparam logic [4:0] c_ALU_SRA = 5'd7;
    localparam logic [4:0] c_ALU_OR  = 5'd8;
    localparam logic [4:0] c_ALU_AND = 5'd9;

    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

`ifdef ALU_ISSUE_BRANCH_EN
    localparam logic [4:0] c_ALU_EQ     = 5'd10;
    localparam logic [4:0] c_ALU_NE     = 5'd11;
    localparam logic [4:0] c_ALU_GE     = 5'd12;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_br;
    logic        r_inv;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_is_shift;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [4:0]  w_ctl;
    logic [4:0]  w_rd;
    logic        w_br;
    logic        w_inv;
    logic        w_illegal;
    logic        w_accept;
    logic        w_unused;

    assign w_opcode   = INSTR[6:0];
    assign w_funct3   = INSTR[14:12];
    assign w_funct7   = INSTR[31:25];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    // Operand values arrive on RS1_VAL/RS2_VAL, so the rs1 field is never decoded.
    assign w_unused   = ^INSTR[19:15];

    assign IN_READY = (r_state == S_IDLE) || ((r_state == S_DONE) && RES_READY);
    assign w_accept = IN_VALID && IN_READY;
    assign RES_BR   = r_br;

    function automatic logic [4:0] f_alu_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_LT;
            3'b011:  op = c_ALU_LTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        w_op1     = RS1_VAL;
        w_op2     = RS2_VAL;
        w_ctl     = c_ALU_ADD;
        w_rd      = INSTR[11:7];
        w_br      = 1'b0;
        w_inv     = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                if ((w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT)) begin
                    w_illegal = 1'b1;
                end else if ((w_funct7 == c_F7_ALT) && (w_funct3 != 3'b000) && (w_funct3 != 3'b101)) begin
                    w_illegal = 1'b1;
                end else begin
                    w_ctl = f_alu_op(w_funct3, w_funct7[5]);
                    if (w_is_shift) begin
                        w_op2 = {27'b0, RS2_VAL[4:0]};
                    end
                end
            end
            c_OPC_OPIMM: begin
                w_op2 = {{20{INSTR[31]}}, INSTR[31:20]};
                if (w_is_shift) begin
                    w_op2 = {27'b0, INSTR[24:20]};
                    // SLLI only accepts the base funct7; SRLI/SRAI differ in bit 30.
                    if ((w_funct3 == 3'b001) ? (w_funct7 != c_F7_BASE)
                                             : ((w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT))) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_ctl = f_alu_op(w_funct3, INSTR[30]);
                    end
                end else begin
                    w_ctl = f_alu_op(w_funct3, 1'b0);
                end
            end
`ifdef ALU_ISSUE_BRANCH_EN
            c_OPC_BRANCH: begin
                w_rd = 5'd0;
                w_br = 1'b1;
                case (w_funct3)
                    3'b000:  w_ctl = c_ALU_EQ;
                    3'b001:  w_ctl = c_ALU_NE;
                    3'b100:  w_ctl = c_ALU_LT;
                    3'b101:  w_ctl = c_ALU_GE;
                    3'b110:  w_ctl = c_ALU_LTU;
                    3'b111: begin
                        w_ctl = c_ALU_LTU;
                        w_inv = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
`endif
            default: w_illegal = 1'b1;
        endcase
        // Illegal instructions present ADD 0,0 to the ALU and retire with rd=0.
        if (w_illegal) begin
            w_op1 = 32'd0;
            w_op2 = 32'd0;
            w_ctl = c_ALU_ADD;
            w_rd  = 5'd0;
            w_br  = 1'b0;
            w_inv = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            RES_VALID <= 1'b0;
            RES       <= 32'd0;
            RES_RD    <= 5'd0;
            r_br      <= 1'b0;
            r_inv     <= 1'b0;
            ILLEGAL   <= 1'b0;
            OP1       <= 32'd0;
            OP2       <= 32'd0;
            CTL       <= c_ALU_ADD;
        end else if (w_accept) begin
            r_state   <= S_EXEC;
            RES_VALID <= 1'b0;
            OP1       <= w_op1;
            OP2       <= w_op2;
            CTL       <= w_ctl;
            RES_RD    <= w_rd;
            r_br      <= w_br;
            r_inv     <= w_inv;
            ILLEGAL   <= w_illegal;
        end else begin
            case (r_state)
                S_EXEC: begin
                    if (ILLEGAL) begin
                        RES <= 32'd0;
                    end else if (r_br) begin
                        RES <= {31'b0, ALU_OUT[0] ^ r_inv};
                    end else begin
                        RES <= ALU_OUT;
                    end
                    RES_VALID <= 1'b1;
                    r_state   <= S_DONE;
                    // Operands return to the idle value once the result is latched.
                    OP1       <= 32'd0;
                    OP2       <= 32'd0;
                    CTL       <= c_ALU_ADD;
                end
                S_DONE: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    RES_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
//==========================================================================
// Module   : tb_alu_issue
// Purpose  : Self-checking bench for alu_issue with an attached ALU model.
// Revision : 1.0
//==========================================================================
module tb_alu_issue;

    localparam logic [4:0] c_ALU_ADD = 5'd0;
    localparam logic [4:0] c_ALU_SUB = 5'd1;
    localparam logic [4:0] c_ALU_SLL = 5'd2;
    localparam logic [4:0] c_ALU_LT  = 5'd3;
    localparam logic [4:0] c_ALU_LTU = 5'd4;
    localparam logic [4:0] c_ALU_XOR = 5'd5;
    localparam logic [4:0] c_ALU_SRL = 5'd6;
    localparam logic [4:0] c_ALU_SRA = 5'd7;
    localparam logic [4:0] c_ALU_OR  = 5'd8;
    localparam logic [4:0] c_ALU_AND = 5'd9;
    localparam logic [4:0] c_ALU_EQ  = 5'd10;
    localparam logic [4:0] c_ALU_NE  = 5'd11;
    localparam logic [4:0] c_ALU_GE  = 5'd12;

`ifdef ALU_ISSUE_BRANCH_EN
    localparam bit c_BR_EN = 1'b1;
`else
    localparam bit c_BR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] INSTR;
    logic [31:0] RS1_VAL;
    logic [31:0] RS2_VAL;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [4:0]  CTL;
    logic [31:0] ALU_OUT;
    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES;
    logic [4:0]  RES_RD;
    logic        RES_BR;
    logic        ILLEGAL;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    alu_issue dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .RS1_VAL   (RS1_VAL),
        .RS2_VAL   (RS2_VAL),
        .OP1       (OP1),
        .OP2       (OP2),
        .CTL       (CTL),
        .ALU_OUT   (ALU_OUT),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES       (RES),
        .RES_RD    (RES_RD),
        .RES_BR    (RES_BR),
        .ILLEGAL   (ILLEGAL)
    );

    // External combinational ALU the block is meant to drive.
    always_comb begin
        case (CTL)
            c_ALU_ADD: ALU_OUT = OP1 + OP2;
            c_ALU_SUB: ALU_OUT = OP1 - OP2;
            c_ALU_SLL: ALU_OUT = OP1 << OP2[4:0];
            c_ALU_LT:  ALU_OUT = {31'b0, $signed(OP1) < $signed(OP2)};
            c_ALU_LTU: ALU_OUT = {31'b0, OP1 < OP2};
            c_ALU_XOR: ALU_OUT = OP1 ^ OP2;
            c_ALU_SRL: ALU_OUT = OP1 >> OP2[4:0];
            c_ALU_SRA: ALU_OUT = $unsigned($signed(OP1) >>> OP2[4:0]);
            c_ALU_OR:  ALU_OUT = OP1 | OP2;
            c_ALU_AND: ALU_OUT = OP1 & OP2;
            c_ALU_EQ:  ALU_OUT = {31'b0, OP1 == OP2};
            c_ALU_NE:  ALU_OUT = {31'b0, OP1 != OP2};
            c_ALU_GE:  ALU_OUT = {31'b0, $signed(OP1) >= $signed(OP2)};
            default:   ALU_OUT = 32'hDEAD_BEEF;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        br;
        logic        ill;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] r, input logic [4:0] rd,
                                input logic br, input logic ill);
        vec_t v;
        v.name = n; v.instr = ins; v.rs1 = a; v.rs2 = b;
        v.res = r; v.rd = rd; v.br = br; v.ill = ill;
        return v;
    endfunction

    function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] f_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] f_b(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    // Instruction semantics straight from the RV32I definitions.
    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic [4:0] rd,
                                      output logic br, output logic ill);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        res = 32'd0; rd = 5'd0; br = 1'b0; ill = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    res = arith(f3, f7 == 7'h20, a, b);
                    rd  = ins[11:7];
                end else ill = 1'b1;
            end
            7'b0010011: begin
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
                else begin
                    if (f3 == 3'd1 || f3 == 3'd5) res = arith(f3, f7 == 7'h20, a, {27'b0, ins[24:20]});
                    else                          res = arith(f3, 1'b0, a, imm);
                    rd = ins[11:7];
                end
            end
            7'b1100011: begin
                if (c_BR_EN && f3 != 3'd2 && f3 != 3'd3) begin
                    br = 1'b1;
                    case (f3)
                        3'd0:    res = {31'b0, a == b};
                        3'd1:    res = {31'b0, a != b};
                        3'd4:    res = {31'b0, $signed(a) < $signed(b)};
                        3'd5:    res = {31'b0, $signed(a) >= $signed(b)};
                        3'd6:    res = {31'b0, a < b};
                        default: res = {31'b0, a >= b};
                    endcase
                end else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [4:0] rd, output logic br,
                         output logic ill, output logic [31:0] op2_exec, output int lat);
        int waited = 0;
        while (!IN_READY && waited < 50) begin
            @(posedge CLK); #1;
            waited++;
        end
        check("issue_in_ready", {31'b0, IN_READY}, 32'd1);
        IN_VALID = 1'b1; INSTR = ins; RS1_VAL = a; RS2_VAL = b; RES_READY = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; INSTR = $urandom; RS1_VAL = $urandom; RS2_VAL = $urandom;
        op2_exec = OP2;
        lat = 1;
        while (!RES_VALID && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        res = RES; rd = RES_RD; br = RES_BR; ill = ILLEGAL;
        RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
    endtask

    task automatic check_txn(input string tag, input logic [31:0] ins, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] er, input logic [4:0] erd,
                             input logic ebr, input logic eill);
        logic [31:0] res, op2;
        logic [4:0]  rd;
        logic        br, ill;
        int          lat;
        issue(ins, a, b, res, rd, br, ill, op2, lat);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_res"}, res, er);
        check({tag, "_rd"}, {27'b0, rd}, {27'b0, erd});
        check({tag, "_br"}, {31'b0, br}, {31'b0, ebr});
        check({tag, "_illegal"}, {31'b0, ill}, {31'b0, eill});
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] res, op2;
        logic [4:0]  rd;
        logic        br, ill;
        int          lat;

        RST = 1'b1; IN_VALID = 1'b0; RES_READY = 1'b0;
        INSTR = 32'd0; RS1_VAL = 32'd0; RS2_VAL = 32'd0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_in_ready", {31'b0, IN_READY}, 32'd1);
        check("rst_res_valid", {31'b0, RES_VALID}, 32'd0);
        check("rst_res", RES, 32'd0);
        check("rst_res_rd", {27'b0, RES_RD}, 32'd0);
        check("rst_res_br", {31'b0, RES_BR}, 32'd0);
        check("rst_illegal", {31'b0, ILLEGAL}, 32'd0);
        check("rst_op1", OP1, 32'd0);
        check("rst_op2", OP2, 32'd0);
        check("rst_ctl", {27'b0, CTL}, {27'b0, c_ALU_ADD});

        vecs.push_back(mk("add",   f_r(7'h00, 3'b000, 5'd3),  32'd5,        32'd7,        32'd12,        5'd3,  1'b0, 1'b0));
        vecs.push_back(mk("sub",   f_r(7'h20, 3'b000, 5'd4),  32'd5,        32'd7,        32'hFFFFFFFE,  5'd4,  1'b0, 1'b0));
        vecs.push_back(mk("sra",   f_r(7'h20, 3'b101, 5'd5),  32'h80000000, 32'h00000021, 32'hC0000000,  5'd5,  1'b0, 1'b0));
        vecs.push_back(mk("sltu",  f_r(7'h00, 3'b011, 5'd6),  32'd1,        32'hFFFFFFFF, 32'd1,         5'd6,  1'b0, 1'b0));
        vecs.push_back(mk("slt",   f_r(7'h00, 3'b010, 5'd7),  32'hFFFFFFFF, 32'd1,        32'd1,         5'd7,  1'b0, 1'b0));
        vecs.push_back(mk("xor",   f_r(7'h00, 3'b100, 5'd8),  32'hF0F01234, 32'h0FF000FF, 32'hFF0012CB,  5'd8,  1'b0, 1'b0));
        vecs.push_back(mk("or",    f_r(7'h00, 3'b110, 5'd9),  32'hF0F01234, 32'h0FF000FF, 32'hFFF012FF,  5'd9,  1'b0, 1'b0));
        vecs.push_back(mk("and",   f_r(7'h00, 3'b111, 5'd10), 32'hF0F01234, 32'h0FF000FF, 32'h00F00034,  5'd10, 1'b0, 1'b0));
        vecs.push_back(mk("sll",   f_r(7'h00, 3'b001, 5'd11), 32'd1,        32'h00000025, 32'h00000020,  5'd11, 1'b0, 1'b0));
        vecs.push_back(mk("srl",   f_r(7'h00, 3'b101, 5'd12), 32'h80000000, 32'd4,        32'h08000000,  5'd12, 1'b0, 1'b0));
        vecs.push_back(mk("addi",  f_i(12'hFFF, 3'b000, 5'd13), 32'd1,      32'd99,       32'd0,         5'd13, 1'b0, 1'b0));
        vecs.push_back(mk("srai",  f_i({7'h20, 5'd4}, 3'b101, 5'd14), 32'h80000000, 32'hFFFFFFFF, 32'hF8000000, 5'd14, 1'b0, 1'b0));
        vecs.push_back(mk("sltiu", f_i(12'hFFF, 3'b011, 5'd15), 32'd5,      32'd0,        32'd1,         5'd15, 1'b0, 1'b0));
        vecs.push_back(mk("xori",  f_i(12'h0F0, 3'b100, 5'd16), 32'h000000FF, 32'd0,      32'h0000000F,  5'd16, 1'b0, 1'b0));
        vecs.push_back(mk("slli",  f_i({7'h00, 5'd3}, 3'b001, 5'd17), 32'd3, 32'd0,       32'h00000018,  5'd17, 1'b0, 1'b0));
        vecs.push_back(mk("ill_mul",  f_r(7'h01, 3'b000, 5'd18), 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b1));
        vecs.push_back(mk("ill_altx", f_r(7'h20, 3'b100, 5'd19), 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b1));
        vecs.push_back(mk("ill_slli", f_i({7'h20, 5'd1}, 3'b001, 5'd20), 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b1));
        vecs.push_back(mk("ill_load", {12'd0, 5'd1, 3'b010, 5'd21, 7'b0000011}, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b1));
        vecs.push_back(mk("bgeu",  f_b(3'b111), 32'd3, 32'd3, c_BR_EN ? 32'd1 : 32'd0, 5'd0, c_BR_EN, !c_BR_EN));
        vecs.push_back(mk("bne",   f_b(3'b001), 32'd3, 32'd3, 32'd0, 5'd0, c_BR_EN, !c_BR_EN));
        vecs.push_back(mk("blt",   f_b(3'b100), 32'hFFFFFFFF, 32'd1, c_BR_EN ? 32'd1 : 32'd0, 5'd0, c_BR_EN, !c_BR_EN));
        vecs.push_back(mk("ill_b010", f_b(3'b010), 32'd3, 32'd3, 32'd0, 5'd0, 1'b0, 1'b1));

        foreach (vecs[i])
            check_txn(vecs[i].name, vecs[i].instr, vecs[i].rs1, vecs[i].rs2,
                      vecs[i].res, vecs[i].rd, vecs[i].br, vecs[i].ill);

        // Shift amount operand is masked to five bits in EXEC.
        issue(f_r(7'h20, 3'b101, 5'd5), 32'h80000000, 32'h00000021, res, rd, br, ill, op2, lat);
        check("sra_op2", op2, 32'd1);
        check("sra_res", res, 32'hC0000000);

        // Consumer stall: result and flags hold, no new instruction is taken.
        IN_VALID = 1'b1; INSTR = f_i(12'hFFF, 3'b000, 5'd13); RS1_VAL = 32'd1; RS2_VAL = 32'd0;
        @(posedge CLK); #1;
        INSTR = f_r(7'h00, 3'b000, 5'd3); RS1_VAL = 32'd5; RS2_VAL = 32'd7;
        @(posedge CLK); #1;
        for (int k = 0; k < 5; k++) begin
            check("stall_res_valid", {31'b0, RES_VALID}, 32'd1);
            check("stall_res", RES, 32'd0);
            check("stall_res_rd", {27'b0, RES_RD}, 32'd13);
            check("stall_in_ready", {31'b0, IN_READY}, 32'd0);
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0; RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
        check("stall_release_valid", {31'b0, RES_VALID}, 32'd0);
        check("idle_in_ready", {31'b0, IN_READY}, 32'd1);
        check("idle_op1", OP1, 32'd0);
        check("idle_op2", OP2, 32'd0);
        check("idle_ctl", {27'b0, CTL}, {27'b0, c_ALU_ADD});

        // Back-to-back issue through DONE without an IDLE cycle.
        IN_VALID = 1'b1; INSTR = f_r(7'h00, 3'b000, 5'd3); RS1_VAL = 32'd5; RS2_VAL = 32'd7;
        @(posedge CLK); #1;
        INSTR = f_r(7'h20, 3'b000, 5'd4); RS1_VAL = 32'd20; RS2_VAL = 32'd7; RES_READY = 1'b1;
        check("b2b_exec_in_ready", {31'b0, IN_READY}, 32'd0);
        @(posedge CLK); #1;
        check("b2b_first_valid", {31'b0, RES_VALID}, 32'd1);
        check("b2b_first_res", RES, 32'd12);
        check("b2b_first_rd", {27'b0, RES_RD}, 32'd3);
        check("b2b_done_in_ready", {31'b0, IN_READY}, 32'd1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check("b2b_second_exec_valid", {31'b0, RES_VALID}, 32'd0);
        check("b2b_second_exec_ready", {31'b0, IN_READY}, 32'd0);
        @(posedge CLK); #1;
        check("b2b_second_valid", {31'b0, RES_VALID}, 32'd1);
        check("b2b_second_res", RES, 32'd13);
        check("b2b_second_rd", {27'b0, RES_RD}, 32'd4);
        @(posedge CLK); #1;
        RES_READY = 1'b0;
        check("b2b_drain_valid", {31'b0, RES_VALID}, 32'd0);

        // Reset while the instruction is in EXEC.
        IN_VALID = 1'b1; INSTR = f_r(7'h00, 3'b000, 5'd3); RS1_VAL = 32'd5; RS2_VAL = 32'd7;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check("rexec_in_exec_ready", {31'b0, IN_READY}, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rexec_in_ready", {31'b0, IN_READY}, 32'd1);
        check("rexec_res_rd", {27'b0, RES_RD}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("rexec_res_valid", {31'b0, RES_VALID}, 32'd0);
            @(posedge CLK); #1;
        end

        // Reset while the result waits in DONE.
        IN_VALID = 1'b1; INSTR = f_r(7'h00, 3'b000, 5'd3); RS1_VAL = 32'd5; RS2_VAL = 32'd7;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        check("rdone_pre_valid", {31'b0, RES_VALID}, 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rdone_res_valid", {31'b0, RES_VALID}, 32'd0);
        check("rdone_res", RES, 32'd0);
        check("rdone_in_ready", {31'b0, IN_READY}, 32'd1);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ins, a, b, er;
            logic [4:0]  erd, rdf;
            logic [6:0]  f7;
            logic [2:0]  f3;
            logic        ebr, eill;
            int          kind, pick;
            kind = $urandom_range(0, 3);
            f3   = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 9);
            f7   = (pick < 5) ? 7'h00 : (pick < 8) ? 7'h20 : 7'($urandom);
            rdf  = 5'($urandom);
            if (kind == 1 && f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom);
            case (kind)
                0:       ins = {f7, 5'($urandom), 5'($urandom), f3, rdf, 7'b0110011};
                1:       ins = {f7, 5'($urandom), 5'($urandom), f3, rdf, 7'b0010011};
                2:       ins = {7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b1100011};
                default: ins = $urandom;
            endcase
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 4) == 0) b = a;
            ref_model(ins, a, b, er, erd, ebr, eill);
            check_txn("rand", ins, a, b, er, erd, ebr, eill);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
